// File: rtl/zbus_pkg.sv
// Shared encodings for the Z80-style bus master: command codes, FSM states
// and the bus strobe bundle.
package zbus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_OPF  = 3'd1,
        CMD_MRD  = 3'd2,
        CMD_MWR  = 3'd3,
        CMD_IORD = 3'd4,
        CMD_IOWR = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5
    } state_e;

    typedef struct packed {
        logic m1_n;
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic rfsh_n;
    } strobes_t;

    localparam strobes_t STB_IDLE = '1;

    function automatic logic cmd_valid(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd5);
    endfunction

    function automatic logic is_io(input cmd_e c);
        return (c == CMD_IORD) || (c == CMD_IOWR);
    endfunction

endpackage

// File: rtl/zbus_master.sv
// Z80-style bus cycle generator: turns one command into an OPF, memory or I/O
// machine cycle, timed by zpos/zneg strobes derived from the Z80 clock.
module zbus_master
    import zbus_pkg::*;
(
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        req,
    output logic        ack,
    input  logic [2:0]  cmd,
    input  logic [15:0] caddr,
    input  logic [7:0]  cdata,
    input  logic [7:0]  ireg,
    input  logic        wait_n,
    input  logic [7:0]  din,
    output logic [15:0] a,
    output logic [7:0]  dout,
    output logic        doe,
    output logic        m1_n,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        rfsh_n,
    output logic [7:0]  rdata,
    output logic        done
);

    state_e      state, state_nxt;
    cmd_e        cur_cmd, cur_cmd_nxt;
    strobes_t    stb, stb_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        wt, wt_nxt;
    logic [6:0]  r_cnt, r_nxt;
    logic [15:0] a_nxt;
    logic [7:0]  dout_nxt, rdata_nxt;
    logic        doe_nxt, ack_nxt, done_nxt;
    logic        zp, zn, accept;

    // A coincident zneg is dropped so zpos alone decides the edge.
    assign zp = zpos;
    assign zn = zneg & ~zpos;

    assign m1_n   = stb.m1_n;
    assign mreq_n = stb.mreq_n;
    assign iorq_n = stb.iorq_n;
    assign rd_n   = stb.rd_n;
    assign wr_n   = stb.wr_n;
    assign rfsh_n = stb.rfsh_n;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_cmd <= CMD_IDLE;
            stb     <= STB_IDLE;
            data_q  <= '0;
            wt      <= 1'b0;
            r_cnt   <= '0;
            a       <= '0;
            dout    <= '0;
            doe     <= 1'b0;
            rdata   <= '0;
            ack     <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values.
            state   <= state_nxt;
            cur_cmd <= cur_cmd_nxt;
            stb     <= stb_nxt;
            data_q  <= data_nxt;
            wt      <= wt_nxt;
            r_cnt   <= r_nxt;
            a       <= a_nxt;
            dout    <= dout_nxt;
            doe     <= doe_nxt;
            rdata   <= rdata_nxt;
            ack     <= ack_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (zp) begin
            case (state)
                S_IDLE:  if (req && cmd_valid(cmd)) state_nxt = S_T1;
                S_T1:    state_nxt = S_T2;
                S_T2:    state_nxt = (is_io(cur_cmd) || wt) ? S_TW : S_T3;
                S_TW:    state_nxt = wt ? S_TW : S_T3;
                S_T3: begin
                    if (cur_cmd == CMD_OPF)          state_nxt = S_T4;
                    else if (req && cmd_valid(cmd)) state_nxt = S_T1;
                    else                            state_nxt = S_IDLE;
                end
                S_T4:    state_nxt = (req && cmd_valid(cmd)) ? S_T1 : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // T1 is only ever reached from a zpos that accepts a command.
    assign accept = zp && (state_nxt == S_T1);

    always_comb begin
        // NOTE: every *_nxt gets a default first, so no path can infer a latch.
        cur_cmd_nxt = cur_cmd;
        stb_nxt     = stb;
        data_nxt    = data_q;
        wt_nxt      = wt;
        r_nxt       = r_cnt;
        a_nxt       = a;
        dout_nxt    = dout;
        doe_nxt     = doe;
        rdata_nxt   = rdata;
        ack_nxt     = 1'b0;
        done_nxt    = 1'b0;
        if (zp) begin
            case (state)
                S_IDLE: doe_nxt = 1'b0;
                S_T1: begin
                    if (is_io(cur_cmd)) begin
                        stb_nxt.iorq_n = 1'b0;
                        if (cur_cmd == CMD_IORD) begin
                            stb_nxt.rd_n = 1'b0;
                        end else begin
                            stb_nxt.wr_n = 1'b0;
                            dout_nxt     = data_q;
                            doe_nxt      = 1'b1;
                        end
                    end
                end
                S_T2, S_TW: begin
                    if (cur_cmd == CMD_OPF && state_nxt == S_T3) begin
                        rdata_nxt      = din;
                        stb_nxt.m1_n   = 1'b1;
                        stb_nxt.mreq_n = 1'b1;
                        stb_nxt.rd_n   = 1'b1;
                        stb_nxt.rfsh_n = 1'b0;
                        a_nxt          = {ireg, 1'b0, r_cnt};
                    end
                end
                S_T4: begin
                    stb_nxt.rfsh_n = 1'b1;
                    done_nxt       = 1'b1;
                    r_nxt          = r_cnt + 7'd1;
                end
                default: ;
            endcase
            if (accept) begin
                ack_nxt      = 1'b1;
                cur_cmd_nxt  = cmd_e'(cmd);
                data_nxt     = cdata;
                a_nxt        = caddr;
                doe_nxt      = 1'b0;
                wt_nxt       = 1'b0;
                stb_nxt.m1_n = (cmd_e'(cmd) != CMD_OPF);
            end
        end else if (zn) begin
            case (state)
                S_T1: begin
                    if (!is_io(cur_cmd)) begin
                        stb_nxt.mreq_n = 1'b0;
                        if (cur_cmd == CMD_MWR) begin
                            dout_nxt = data_q;
                            doe_nxt  = 1'b1;
                        end else begin
                            stb_nxt.rd_n = 1'b0;
                        end
                    end
                end
                S_T2: begin
                    if (!is_io(cur_cmd)) begin
                        wt_nxt = ~wait_n;
                        if (cur_cmd == CMD_MWR) stb_nxt.wr_n = 1'b0;
                    end
                end
                S_TW: wt_nxt = ~wait_n;
                S_T3: begin
                    if (cur_cmd == CMD_OPF) begin
                        stb_nxt.mreq_n = 1'b0;
                    end else begin
                        stb_nxt  = STB_IDLE;
                        done_nxt = 1'b1;
                        if (cur_cmd == CMD_MRD || cur_cmd == CMD_IORD) rdata_nxt = din;
                    end
                end
                S_T4: stb_nxt.mreq_n = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zbus_master.sv
// Scoreboard bench for zbus_master: expected cycle shapes are queued at issue
// time and compared when the DUT signals done or raises a refresh strobe.
module tb_zbus_master;
    import zbus_pkg::*;

    localparam int ZP = 8;

    typedef struct {
        cmd_e        cmd;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  din;
        int          n;
        int          zp;
        int          lo;
    } txn_t;

    logic        fclk = 1'b0, rst_n = 1'b0, zpos = 1'b0, zneg = 1'b0;
    logic        req = 1'b0, wait_n = 1'b1;
    logic [2:0]  cmd = 3'd0;
    logic [15:0] caddr = '0;
    logic [7:0]  cdata = '0, ireg = 8'h3F, din = '0;
    logic        ack, doe, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, done;
    logic [15:0] a;
    logic [7:0]  dout, rdata;

    txn_t        sb[$];
    logic [15:0] rq[$];
    int          n_checks = 0, n_errors = 0, cyc = 0;
    int          last_ack_cyc = 0, last_done_cyc = 0;
    int          nxt_lo = 1, nxt_hi = 0, cur_lo = 1, cur_hi = 0, zn_k = 0;
    logic [7:0]  nxt_din = '0;
    logic [6:0]  r_model = '0;

    zbus_master dut (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .req(req), .ack(ack),
        .cmd(cmd), .caddr(caddr), .cdata(cdata), .ireg(ireg), .wait_n(wait_n), .din(din),
        .a(a), .dout(dout), .doe(doe), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .rdata(rdata), .done(done)
    );

    initial forever #5 fclk = ~fclk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Z-clock strobes plus wait_n/din, windowed per cycle by zneg index since ack.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge fclk);
            if (ack) begin
                cur_lo = nxt_lo;
                cur_hi = nxt_hi;
                din    = nxt_din;
                zn_k   = 0;
            end
            phase = (phase + 1) % ZP;
            zpos  = (phase == 0);
            zneg  = (phase == ZP / 2);
            if (zneg) begin
                wait_n = (zn_k >= cur_lo && zn_k <= cur_hi) ? 1'b0 : 1'b1;
                zn_k++;
            end else begin
                wait_n = 1'b1;
            end
        end
    end

    initial begin
        txn_t e;
        logic prev_mreq, prev_iorq, prev_wr, prev_rfsh, seen_mreq, in_cycle;
        int   zp_cnt, rd_lo, wr_lo, m1_lo;
        prev_mreq = 1'b1; prev_iorq = 1'b1; prev_wr = 1'b1; prev_rfsh = 1'b1;
        seen_mreq = 1'b0; in_cycle = 1'b0;
        zp_cnt = 0; rd_lo = 0; wr_lo = 0; m1_lo = 0;
        forever begin
            @(posedge fclk);
            #1;
            cyc++;
            if (!rst_n) begin
                sb.delete();
                rq.delete();
                in_cycle = 1'b0;
                prev_mreq = 1'b1; prev_iorq = 1'b1; prev_wr = 1'b1; prev_rfsh = 1'b1;
                continue;
            end
            if (zpos && in_cycle) zp_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("cycle_zclocks", zp_cnt, e.zp);
                    check("done_phase", 32'({zpos, zneg}), (e.cmd == CMD_OPF) ? 32'd2 : 32'd1);
                    if (e.cmd == CMD_OPF || e.cmd == CMD_MRD || e.cmd == CMD_IORD) begin
                        check("rdata", 32'(rdata), 32'(e.din));
                        check("rd_low_fclks", rd_lo, e.lo);
                    end else begin
                        check("wr_low_fclks", wr_lo, e.lo);
                    end
                    if (e.cmd == CMD_OPF) check("m1_low_fclks", m1_lo, (2 + e.n) * ZP);
                    else                  check("cycle_addr", 32'(a), 32'(e.addr));
                end
                in_cycle = 1'b0;
                last_done_cyc = cyc;
            end
            if (ack) begin
                in_cycle = 1'b1;
                zp_cnt = 0; rd_lo = 0; wr_lo = 0; m1_lo = 0;
                seen_mreq = 1'b0;
                last_ack_cyc = cyc;
            end
            if (in_cycle) begin
                if (!rd_n) rd_lo++;
                if (!wr_n) wr_lo++;
                if (!m1_n) m1_lo++;
                if (!mreq_n && prev_mreq && !seen_mreq) begin
                    seen_mreq = 1'b1;
                    check("mreq_fall_zneg", 32'(zneg), 32'd1);
                    check("mreq_fall_t1", zp_cnt, 0);
                end
                if (!iorq_n && prev_iorq) begin
                    check("iorq_fall_zpos", 32'(zpos), 32'd1);
                    check("iorq_fall_t2", zp_cnt, 1);
                end
                if (!wr_n && prev_wr && sb.size() > 0) begin
                    check("wr_dout", 32'(dout), 32'(sb[0].data));
                    check("wr_doe", 32'(doe), 32'd1);
                end
            end
            if (!rfsh_n && prev_rfsh) begin
                if (rq.size() == 0) check("rfsh_unexpected", 32'd1, 32'd0);
                else                check("rfsh_addr", 32'(a), 32'(rq.pop_front()));
            end
            prev_mreq = mreq_n; prev_iorq = iorq_n; prev_wr = wr_n; prev_rfsh = rfsh_n;
        end
    end

    task automatic issue(input cmd_e c, input logic [15:0] ad, input logic [7:0] dt,
                         input logic [7:0] dv, input int n);
        txn_t e;
        bit   got;
        e.cmd = c; e.addr = ad; e.data = dt; e.din = dv; e.n = n;
        case (c)
            CMD_OPF: begin e.zp = 4 + n; e.lo = ZP * 3 / 2 + ZP * n; end
            CMD_MRD: begin e.zp = 2 + n; e.lo = 2 * ZP + ZP * n;     end
            CMD_MWR: begin e.zp = 2 + n; e.lo = ZP + ZP * n;         end
            default: begin e.zp = 3 + n; e.lo = ZP * 5 / 2 + ZP * n; end
        endcase
        if (c == CMD_IORD || c == CMD_IOWR) begin nxt_lo = 2; nxt_hi = 1 + n; end
        else                                 begin nxt_lo = 1; nxt_hi = n;     end
        nxt_din = dv;
        sb.push_back(e);
        if (c == CMD_OPF) begin
            rq.push_back({ireg, 1'b0, r_model});
            r_model = r_model + 7'd1;
        end
        @(negedge fclk);
        req = 1'b1; cmd = c; caddr = ad; cdata = dt;
        got = 1'b0;
        for (int i = 0; i < 40 * ZP; i++) begin
            @(posedge fclk);
            #1;
            if (ack) begin got = 1'b1; break; end
        end
        req = 1'b0;
        cmd = CMD_IDLE;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge fclk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 * ZP && sb.size() > 0; i++) @(posedge fclk);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        cmd_e c;
        rst_n = 1'b0;
        repeat (5) @(posedge fclk);
        #1;
        check("rst_strobes", 32'({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}), 32'h3F);
        check("rst_a", 32'(a), 32'd0);
        check("rst_dout_rdata", 32'({dout, rdata}), 32'd0);
        check("rst_doe_ack_done", 32'({doe, ack, done}), 32'd0);
        @(negedge fclk);
        rst_n = 1'b1;

        issue(CMD_OPF, 16'h0000, 8'h00, 8'h3E, 0);
        issue(CMD_OPF, 16'h0001, 8'h00, 8'hC9, 0);
        drain();

        issue(CMD_MRD, 16'h1234, 8'h00, 8'h5A, 2);
        issue(CMD_MWR, 16'h4000, 8'hAA, 8'h00, 0);
        check("b2b_mrd_mwr_gap", last_ack_cyc - last_done_cyc, ZP / 2);
        drain();
        repeat (3 * ZP) @(posedge fclk);
        #1;
        check("idle_doe", 32'(doe), 32'd0);
        check("idle_strobes", 32'({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}), 32'h3F);
        check("idle_a_hold", 32'(a), 32'h4000);

        issue(CMD_IOWR, 16'h7FFE, 8'h07, 8'h00, 0);
        issue(CMD_IORD, 16'h00FE, 8'h00, 8'h81, 1);
        drain();

        for (int i = 0; i < 128; i++) issue(CMD_OPF, 16'(i), 8'h00, 8'($urandom), 0);
        check("b2b_opf_gap", last_ack_cyc - last_done_cyc, 0);
        drain();

        for (int i = 0; i < 12; i++) begin
            c = cmd_e'(3'($urandom_range(1, 5)));
            issue(c, 16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end
        drain();

        issue(CMD_MRD, 16'h5555, 8'h00, 8'hA5, 0);
        drain();
        issue(CMD_MRD, 16'h6666, 8'h00, 8'h3C, 5);
        repeat (20) @(posedge fclk);
        @(negedge fclk);
        check("pre_reset_rd_n", 32'(rd_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("tw_reset_strobes", 32'({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}), 32'h3F);
        check("tw_reset_rdata", 32'(rdata), 32'd0);
        check("tw_reset_done", 32'(done), 32'd0);
        repeat (3) @(negedge fclk);
        r_model = '0;
        rst_n = 1'b1;

        issue(CMD_OPF, 16'h0100, 8'h00, 8'h11, 0);
        issue(CMD_MRD, 16'h2222, 8'h00, 8'h33, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zbus_master.md
ZBUS_MASTER -- requirements
Module: zbus_master

Interface
REQ-001 fclk  in  1  system clock; all logic on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 zpos  in  1  one-fclk strobe at each Z80 clock rising edge.
REQ-004 zneg  in  1  one-fclk strobe at each Z80 clock falling edge.
REQ-005 req  in  1  command request; held high until ack.
REQ-006 ack  out  1  one-fclk pulse when a command is accepted.
REQ-007 cmd  in  3  cycle type: OPF, MRD, MWR, IORD, IOWR; other codes are IDLE.
REQ-008 caddr  in  16  cycle address.
REQ-009 cdata  in  8  write data.
REQ-010 ireg  in  8  high byte of the refresh address.
REQ-011 wait_n  in  1  bus wait, active low.
REQ-012 din  in  8  bus data in.
REQ-013 a  out  16  bus address.
REQ-014 dout  out  8  bus data out.
REQ-015 doe  out  1  dout drive enable.
REQ-016 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  out  1 each  bus strobes, active low.
REQ-017 rdata  out  8  captured read data.
REQ-018 done  out  1  one-fclk pulse at the end of a machine cycle.

Function
REQ-019 The block is one FSM: IDLE, T1, T2, TW, T3, T4. Each state spans one zpos-to-zpos period, and each state has sub-phases split at zneg.
REQ-020 IDLE: on a zpos with req=1 and a valid cmd, the block latches cmd, caddr and cdata, pulses ack, and enters T1 on that same edge.
REQ-021 All strobe changes occur on the fclk edge that samples the relevant zpos or zneg strobe (latency 0).
REQ-022 OPF sequence:
  - T1 zpos: a=caddr, m1_n=0.
  - T1 zneg: mreq_n=0, rd_n=0.
  - T3 zpos: rdata<=din; m1_n, mreq_n and rd_n go to 1; rfsh_n=0; a={ireg,R}.
  - T3 zneg: mreq_n=0.
  - T4 zneg: mreq_n=1.
  - T4 end (next zpos): rfsh_n=1, done pulses.
REQ-023 MRD sequence:
  - T1 zpos: address out.
  - T1 zneg: mreq_n=0, rd_n=0.
  - T3 zneg: rdata<=din; mreq_n=1, rd_n=1; done pulses.
REQ-024 MWR sequence:
  - T1 zpos: address out.
  - T1 zneg: mreq_n=0, dout=cdata, doe=1.
  - T2 zneg: wr_n=0.
  - T3 zneg: mreq_n=1, wr_n=1; done pulses.
  - doe stays 1 until the next T1 zpos or IDLE zpos.
REQ-025 IORD/IOWR sequence:
  - T1 zpos: address out.
  - T2 zpos: iorq_n=0, plus rd_n=0 (IORD) or wr_n=0 with doe=1 (IOWR).
  - One TW is always inserted.
  - T3 zneg: iorq_n, rd_n and wr_n go to 1; IORD captures rdata; done pulses.
REQ-026 wait_n is sampled at zneg of T2 (memory cycles) or of the forced TW (I/O cycles). If it is 0, the FSM enters or stays in TW and re-samples at each TW zneg. Strobes hold their values during TW.
REQ-027 R is a 7-bit counter that increments by 1 after each OPF refresh and wraps from 127 to 0. Bit 7 of the refresh address is 0.
REQ-028 Back-to-back: if req=1 at the zpos ending T3 (memory/IO) or T4 (OPF), the block accepts the next command at that zpos with no IDLE state between cycles.
REQ-029 While idle, a holds its last value, all strobes are 1, and doe is 0 except as allowed by REQ-024.
REQ-030 zpos and zneg asserted together: zpos takes effect and zneg is ignored.

Reset
REQ-031 While rst_n=0:
  - FSM is IDLE.
  - All strobes are 1.
  - doe=0, ack=0, done=0.
  - a=0, dout=0, rdata=0, R=0.
REQ-032 Reset asserted mid-cycle releases all strobes immediately, with no done pulse. After reset, the block starts from IDLE at the first zpos with req=1.

Structure
REQ-033 The cmd encodings and FSM state encodings live in a shared package, zbus_pkg.
REQ-034 The design is a single module with no sub-modules.

Verification
REQ-035 OPF at 0x0000, din=0x3E, wait_n=1, ireg=0x3F:
  - m1_n is low for T1-T2.
  - rdata=0x3E.
  - Refresh address is 0x3F00, then 0x3F01 on the next OPF.
REQ-036 MWR to 0x4000, data 0xAA, wait_n=1:
  - mreq_n falls at T1 zneg; wr_n is low for exactly one Z-clock period.
  - dout=0xAA while wr_n=0.
  - done pulses at T3 zneg.
REQ-037 MRD with wait_n=0 for 2 Z-clocks:
  - Exactly 2 TW states are inserted.
  - rd_n is held low throughout.
  - Data sampled after release matches din=0x5A.
REQ-038 IOWR to 0x7FFE, data 0x07:
  - iorq_n falls at T2 zpos; exactly one TW is inserted.
  - Total cycle is 4 Z-clocks.
REQ-039 Sequence:
  - 128 consecutive OPFs: R wraps 0x7F->0x00.
  - Back-to-back MRD then MWR: no idle gap.
REQ-040 rst_n asserted during TW: all strobes are 1 within 1 fclk, no done pulse, and rdata=0.
